// File: rtl/a0_capture_fifo.sv
// rtl/a0_capture_fifo.sv - captures changes of register a0 into a show-ahead FIFO with drop accounting
module a0_capture_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           a0,
    input  logic                       en,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic [7:0]                 drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] prev;
    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;

    logic change;
    logic full;
    logic pop;
    logic push;
    logic drop;

    // A change is only a push when there is room, or when a pop frees a slot on the same edge
    always_comb begin
        change = en && (a0 != prev);
        full   = (count == CW'(DEPTH));
        pop    = out_valid && out_ready;
        push   = change && (!full || pop);
        drop   = change && full && !pop;
    end

    assign out_valid = (count != '0);
    assign out_data  = mem[head];

    // Control state: change tracker, pointers, occupancy and drop accounting
    always_ff @(posedge clk) begin
        if (rst) begin
            prev     <= '0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (change) begin
                prev <= a0;
            end
            if (push) begin
                tail <= tail + AW'(1);
            end
            if (pop) begin
                head <= head + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 8'hFF) begin
                    drop_cnt <= drop_cnt + 8'd1;
                end
            end
        end
    end

    // Storage array is written only on accepted pushes and carries no reset
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[tail] <= a0;
        end
    end

endmodule

// File: tb/tb_a0_capture_fifo.sv
// tb/tb_a0_capture_fifo.sv - randomized and directed self-checking bench for a0_capture_fifo
module tb_a0_capture_fifo;

    localparam int WIDTH = 32;
    localparam int DEPTH = 8;

    logic              clk;
    logic              rst;
    logic [WIDTH-1:0]  a0;
    logic              en;
    logic [WIDTH-1:0]  out_data;
    logic              out_valid;
    logic              out_ready;
    logic [3:0]        count;
    logic              overflow;
    logic [7:0]        drop_cnt;

    int n_pass;
    int n_total;

    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] m_prev;
    logic             m_ovf;
    int               m_drops;

    a0_capture_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .a0(a0),
        .en(en),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .count(count),
        .overflow(overflow),
        .drop_cnt(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: a queue of captured values, applied with the current inputs, then one clock edge
    task automatic cycle();
        bit popping;
        if (rst) begin
            q.delete();
            m_prev  = '0;
            m_ovf   = 1'b0;
            m_drops = 0;
        end else begin
            popping = (q.size() > 0) && out_ready;
            if (popping) void'(q.pop_front());
            if (en && a0 != m_prev) begin
                m_prev = a0;
                if (q.size() < DEPTH) q.push_back(a0);
                else begin
                    m_ovf = 1'b1;
                    if (m_drops < 255) m_drops++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; a0 = 32'h55; out_ready = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;
        n_total++;
        if (count !== 4'd0) $display("FAIL reset_count actual=%0d required=0", count); else n_pass++;
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL reset_valid actual=%0b required=0", out_valid); else n_pass++;
        n_total++;
        if (overflow !== 1'b0 || drop_cnt !== 8'd0)
            $display("FAIL reset_flags actual=%0b/%0d required=0/0", overflow, drop_cnt);
        else n_pass++;
    endtask

    task automatic test_basic_capture();
        logic [WIDTH-1:0] seq [4];
        seq = '{32'd0, 32'd5, 32'd5, 32'd9};
        en = 1'b0; out_ready = 1'b0; a0 = '0;
        do_reset();
        en = 1'b1;
        n_total++;
        for (int i = 0; i < 4; i++) begin
            a0 = seq[i];
            cycle();
            if (i == 1 && (out_valid !== 1'b1 || out_data !== 32'd5)) begin
                $display("FAIL latency actual=%0b/%0d required=1/5", out_valid, out_data);
                n_total++;
            end
        end
        if (count !== 4'd2 || out_data !== 32'd5)
            $display("FAIL basic_fill actual=%0d/%0d required=2/5", count, out_data);
        else n_pass++;
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        n_total++;
        if (count !== 4'd1 || out_data !== 32'd9)
            $display("FAIL basic_pop actual=%0d/%0d required=1/9", count, out_data);
        else n_pass++;
    endtask

    task automatic test_no_change();
        bit seen;
        en = 1'b1; out_ready = 1'b0; a0 = '0;
        do_reset();
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        n_total++;
        if (seen) $display("FAIL no_change actual=valid required=empty"); else n_pass++;
    endtask

    task automatic test_disabled();
        logic [WIDTH-1:0] seq [3];
        seq = '{32'd0, 32'd3, 32'd7};
        en = 1'b0; out_ready = 1'b0; a0 = '0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            a0 = seq[i];
            cycle();
        end
        n_total++;
        if (count !== 4'd0) $display("FAIL disabled_hold actual=%0d required=0", count); else n_pass++;
        en = 1'b1;
        cycle();
        n_total++;
        if (count !== 4'd1 || out_data !== 32'd7)
            $display("FAIL disabled_first actual=%0d/%0d required=1/7", count, out_data);
        else n_pass++;
    endtask

    task automatic test_empty_pop();
        en = 1'b0; out_ready = 1'b1; a0 = 32'd1;
        do_reset();
        for (int i = 0; i < 4; i++) cycle();
        n_total++;
        if (count !== 4'd0 || out_valid !== 1'b0)
            $display("FAIL empty_pop actual=%0d/%0b required=0/0", count, out_valid);
        else n_pass++;
        out_ready = 1'b0;
    endtask

    task automatic test_overflow_and_full_pop();
        en = 1'b1; out_ready = 1'b0; a0 = '0;
        do_reset();
        for (int v = 1; v <= 10; v++) begin
            a0 = WIDTH'(v);
            cycle();
        end
        n_total++;
        if (count !== 4'd8 || overflow !== 1'b1 || drop_cnt !== 8'd2)
            $display("FAIL overflow actual=%0d/%0b/%0d required=8/1/2", count, overflow, drop_cnt);
        else n_pass++;
        n_total++;
        if (out_data !== 32'd1) $display("FAIL overflow_head actual=%0d required=1", out_data); else n_pass++;
        a0 = 32'd11; out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        n_total++;
        if (count !== 4'd8 || drop_cnt !== 8'd2 || out_data !== 32'd2)
            $display("FAIL full_push_pop actual=%0d/%0d/%0d required=8/2/2", count, drop_cnt, out_data);
        else n_pass++;
        out_ready = 1'b1;
        en = 1'b0;
        for (int k = 0; k < 8; k++) begin
            n_total++;
            if (out_data !== ((k == 7) ? 32'd11 : WIDTH'(k + 2)))
                $display("FAIL drain_order idx=%0d actual=%0d required=%0d", k, out_data, (k == 7) ? 11 : k + 2);
            else n_pass++;
            cycle();
        end
        n_total++;
        if (out_valid !== 1'b0 || overflow !== 1'b1)
            $display("FAIL drain_end actual=%0b/%0b required=0/1", out_valid, overflow);
        else n_pass++;
        out_ready = 1'b0;
    endtask

    task automatic test_drop_saturation();
        en = 1'b1; out_ready = 1'b0; a0 = '0;
        do_reset();
        for (int v = 1; v <= DEPTH + 260; v++) begin
            a0 = WIDTH'(v);
            cycle();
        end
        n_total++;
        if (drop_cnt !== 8'd255 || count !== 4'd8 || out_data !== 32'd1)
            $display("FAIL drop_saturate actual=%0d/%0d/%0d required=255/8/1", drop_cnt, count, out_data);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        en = 1'b1; out_ready = 1'b0; a0 = '0;
        do_reset();
        for (int v = 1; v <= 5; v++) begin
            a0 = WIDTH'(v * 3);
            cycle();
        end
        n_total++;
        if (count !== 4'd5) $display("FAIL mid_prefill actual=%0d required=5", count); else n_pass++;
        rst = 1'b1; a0 = 32'd77;
        cycle();
        rst = 1'b0;
        n_total++;
        if (count !== 4'd0 || out_valid !== 1'b0 || overflow !== 1'b0 || drop_cnt !== 8'd0)
            $display("FAIL mid_reset actual=%0d/%0b/%0b/%0d required=0/0/0/0", count, out_valid, overflow, drop_cnt);
        else n_pass++;
        a0 = 32'd4;
        cycle();
        n_total++;
        if (count !== 4'd1 || out_data !== 32'd4)
            $display("FAIL mid_recapture actual=%0d/%0d required=1/4", count, out_data);
        else n_pass++;
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        en = 1'b1; out_ready = 1'b0; a0 = '0;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            rst       = ($urandom_range(0, 99) < 2);
            en        = ($urandom_range(0, 9) < 8);
            out_ready = ($urandom_range(0, 9) < ((i / 300) % 2 == 0 ? 3 : 7));
            a0        = WIDTH'($urandom_range(0, 3));
            cycle();
            n_total++;
            if (int'(count) != q.size() || out_valid !== (q.size() != 0) ||
                (q.size() != 0 && out_data !== q[0]) ||
                overflow !== m_ovf || int'(drop_cnt) != m_drops) begin
                if (errs < 10)
                    $display("FAIL random cyc=%0d actual=cnt%0d/v%0b/d%0h/o%0b/dc%0d required=cnt%0d/o%0b/dc%0d/d%0h",
                             i, count, out_valid, out_data, overflow, drop_cnt,
                             q.size(), m_ovf, m_drops, (q.size() != 0) ? q[0] : '0);
                errs++;
            end else n_pass++;
        end
        rst = 1'b0;
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        rst = 1'b1; en = 1'b0; a0 = '0; out_ready = 1'b0;
        q.delete(); m_prev = '0; m_ovf = 1'b0; m_drops = 0;
        test_reset();
        test_basic_capture();
        test_no_change();
        test_disabled();
        test_empty_pop();
        test_overflow_and_full_pop();
        test_drop_saturation();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
